serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial ripple adder built around the team's half adder cell.
- Latches two WIDTH-bit operands and feeds them LSB-first, one bit per clock, into a full-adder slice. The slice is two half adders plus an OR, with a carry flip-flop.
- Collects the sum bits and presents the WIDTH-bit sum and carry-out with a done pulse.
- Serves as the sequential add stage that drives and consumes the half adder's S/C outputs.

Parameters:
- WIDTH, 8, operand and sum width in bits (must be ≥2).

Ports:
- clk   input   1   rising-edge clock.
- rst   input   1   synchronous, active-high reset.
- start input   1   request to begin an add; accepted only when busy=0.
- A     input   WIDTH   operand A, sampled on the accepting edge only.
- B     input   WIDTH   operand B, sampled on the accepting edge only.
- busy  output  1   high while an add is in progress (state ADD).
- done  output  1   one-cycle pulse; SUM/COUT valid from this cycle.
- SUM   output  WIDTH   registered result A+B mod 2^WIDTH.
- COUT  output  1   registered carry-out of the add.

Behaviour:
- Single clock domain. Reset is synchronous, active-high and has priority over all other activity.
- On rst=1 at an edge:
  - state=IDLE, busy=0, done=0, SUM=0, COUT=0.
  - Internal shift registers, carry flip-flop and bit counter are cleared.
- States:
  - IDLE: busy=0, done=0.
  - ADD: busy=1, done=0.
  - DONE: busy=0, done=1.
- IDLE -> ADD when start=1:
  - Load opA<=A and opB<=B; carry<=0; cnt<=0; clear the sum shift register.
- ADD, each edge:
  - Full-adder slice, all combinational:
    - h1 = HA(opA[0], opB[0]).
    - h2 = HA(h1.S, carry).
    - s = h2.S.
    - c = h1.C | h2.C.
  - Register updates:
    - carry<=c.
    - sumsh <= {s, sumsh[WIDTH-1:1]}.
    - opA and opB shift right by 1, zero-filled.
    - cnt<=cnt+1.
  - When cnt==WIDTH-1 on this edge: SUM<={s, sumsh[WIDTH-1:1]}, COUT<=c, go to DONE.
- DONE:
  - done=1 for exactly one cycle.
  - Then IDLE, or ADD if start=1 in that cycle (back-to-back accept with the same load actions as IDLE).
- Latency:
  - start accepted at edge k.
  - WIDTH add edges, k+1..k+WIDTH.
  - done high during the cycle after edge k+WIDTH.
  - Total WIDTH+1 cycles from accept to done.
- SUM/COUT update only on the final ADD edge and hold otherwise, including across IDLE and a following ADD, until the next completion.
- start while busy=1 is ignored: no reload, no restart, latched operands unaffected.
- A/B changes after acceptance have no effect on the result.
- cnt width is clog2(WIDTH)+1, so there is no wrap before compare. cnt is not used outside ADD.
- rst during ADD aborts the add: no done pulse, SUM/COUT forced to 0, next cycle is IDLE.
- rst and start in the same edge: reset wins and start is dropped.

Test Plan:
- WIDTH=8, reset then start with A=8'h3C, B=8'h42 -> busy high 8 cycles; done pulses on cycle 9 after accept; SUM=8'h7E, COUT=0.
- A=8'hFF, B=8'h01 -> SUM=8'h00, COUT=1; A=8'hFF, B=8'hFF -> SUM=8'hFE, COUT=1.
- start with A=8'h10, B=8'h20; pulse start again with A=8'hFF, B=8'hFF on the 3rd busy cycle -> second start ignored; result SUM=8'h30, COUT=0; single done pulse.
- start with A=8'h80, B=8'h80; assert rst on the 4th busy cycle -> busy=0 and SUM=0, COUT=0 next cycle; no done pulse. Then start A=8'h01, B=8'h02 -> SUM=8'h03.
- start held high continuously with A=8'h0F, B=8'h01, then A=8'hAA, B=8'h55 presented on the done cycle -> first done gives SUM=8'h10, COUT=0. Second add accepted in the done cycle; its done comes 9 cycles later with SUM=8'hFF, COUT=0.
- rst and start asserted in the same cycle with A=8'h01, B=8'h01 -> stays IDLE; busy=0, done=0, SUM=0.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder: latches two operands and adds them LSB-first through a
// half-adder based full-adder slice, one bit per clock.
module serial_adder #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] SUM,
   output logic             COUT
);

   localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-2:0] sum_sh;
   logic             carry;
   logic [CNT_W-1:0] cnt;
   logic             load;
   logic             last;
   logic [1:0]       h1;
   logic [1:0]       h2;
   logic             s;
   logic             c;
   logic [WIDTH-1:0] sum_next;

   // Half adder cell: {carry, sum}.
   function automatic logic [1:0] half_add(input logic x, input logic y);
      return {x & y, x ^ y};
   endfunction

   // Full-adder slice built from two half adders and an OR.
   always_comb begin
      h1       = half_add(op_a[0], op_b[0]);
      h2       = half_add(h1[0], carry);
      s        = h2[0];
      c        = h1[1] | h2[1];
      sum_next = {s, sum_sh};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      load       = 1'b0;
      last       = (state == ADD) && (cnt == CNT_W'(WIDTH - 1));
      case (state)
         IDLE: begin
            if (start) begin
               state_next = ADD;
               load       = 1'b1;
            end
         end
         ADD: begin
            if (last) begin
               state_next = DONE;
            end
         end
         DONE: begin
            if (start) begin
               state_next = ADD;
               load       = 1'b1;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Datapath and registered status; the result only moves on the final add edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy   <= 1'b0;
         done   <= 1'b0;
         SUM    <= '0;
         COUT   <= 1'b0;
         op_a   <= '0;
         op_b   <= '0;
         sum_sh <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
      end else begin
         busy <= (state_next == ADD);
         done <= (state_next == DONE);
         if (load) begin
            op_a   <= A;
            op_b   <= B;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
         end else if (state == ADD) begin
            op_a   <= {1'b0, op_a[WIDTH-1:1]};
            op_b   <= {1'b0, op_b[WIDTH-1:1]};
            sum_sh <= sum_next[WIDTH-1:1];
            carry  <= c;
            cnt    <= cnt + CNT_W'(1);
            if (last) begin
               SUM  <= sum_next;
               COUT <= c;
            end
         end
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: issued adds queue their expected result
// and completion cycle; a monitor checks each done pulse against the queue.
module tb_serial_adder;

   localparam int unsigned W = 8;

   typedef struct {
      logic [W-1:0] sum;
      logic         cout;
      int unsigned  due;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a_drv;
   logic [W-1:0] b_drv;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;

   exp_t         exp_q[$];
   int unsigned  cyc = 0;
   int           n_tests = 0;
   int           n_fail = 0;
   int           busy_run = 0;
   bit           mon_en = 1'b0;
   logic [W-1:0] held_sum;
   logic         held_cout;

   serial_adder #(.WIDTH(W)) dut (
      .clk  (clk),
      .rst  (rst),
      .start(start),
      .A    (a_drv),
      .B    (b_drv),
      .busy (busy),
      .done (done),
      .SUM  (sum),
      .COUT (cout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_tests++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Reference model: plain integer addition of the two operands.
   function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input int unsigned due);
      exp_t         e;
      logic [W:0]   tot;
      tot    = {1'b0, x} + {1'b0, y};
      e.sum  = tot[W-1:0];
      e.cout = tot[W];
      e.due  = due;
      return e;
   endfunction

   // Drive start with operands; an accepted add completes W+1 edges later.
   task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input bit push);
      @(negedge clk);
      a_drv = x;
      b_drv = y;
      start = 1'b1;
      if (push) exp_q.push_back(model(x, y, cyc + 1 + W));
   endtask

   task automatic drain();
      int i;
      i = 0;
      while (exp_q.size() != 0 && i < 4 * W) begin
         @(negedge clk);
         i++;
      end
      if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      @(negedge clk);
   endtask

   task automatic do_add(input logic [W-1:0] x, input logic [W-1:0] y);
      exp_t e;
      issue(x, y, 1'b1);
      e = exp_q[exp_q.size() - 1];
      @(negedge clk);
      start = 1'b0;
      a_drv = W'($urandom);
      b_drv = W'($urandom);
      chk("sum_hold", 32'(sum), 32'(held_sum));
      chk("cout_hold", 32'(cout), 32'(held_cout));
      drain();
      held_sum  = e.sum;
      held_cout = e.cout;
   endtask

   // Monitor: every done pulse must match the oldest outstanding add.
   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_done: got SUM=%0h COUT=%0b expected no done (cycle %0d)", sum, cout, cyc);
            end else begin
               e = exp_q.pop_front();
               chk("sum", 32'(sum), 32'(e.sum));
               chk("cout", 32'(cout), 32'(e.cout));
               chk("done_latency", cyc, e.due);
               chk("busy_cycles", 32'(busy_run), W);
               chk("busy_in_done", 32'(busy), 32'd0);
            end
            busy_run = 0;
         end else if (busy === 1'b1) begin
            busy_run++;
         end else begin
            busy_run = 0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      a_drv = '0;
      b_drv = '0;
      held_sum  = '0;
      held_cout = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_sum", 32'(sum), 32'd0);
      chk("rst_cout", 32'(cout), 32'd0);
      rst    = 1'b0;
      mon_en = 1'b1;

      do_add(8'h3C, 8'h42);
      do_add(8'hFF, 8'h01);
      do_add(8'hFF, 8'hFF);

      // Second start in the third busy cycle must be ignored.
      issue(8'h10, 8'h20, 1'b1);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("ign_busy", 32'(busy), 32'd1);
      a_drv = 8'hFF;
      b_drv = 8'hFF;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      drain();
      repeat (W + 2) @(negedge clk);
      held_sum  = 8'h30;
      held_cout = 1'b0;

      // Reset in the fourth busy cycle aborts the add.
      issue(8'h80, 8'h80, 1'b1);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_sum", 32'(sum), 32'd0);
      chk("abort_cout", 32'(cout), 32'd0);
      held_sum  = '0;
      held_cout = 1'b0;
      repeat (W + 2) @(negedge clk);
      do_add(8'h01, 8'h02);

      // Start held high; new operands presented in the done cycle are accepted.
      issue(8'h0F, 8'h01, 1'b1);
      repeat (W + 1) @(negedge clk);
      chk("held_done", 32'(done), 32'd1);
      chk("held_sum", 32'(sum), 32'h10);
      a_drv = 8'hAA;
      b_drv = 8'h55;
      exp_q.push_back(model(8'hAA, 8'h55, cyc + 1 + W));
      @(negedge clk);
      start = 1'b0;
      chk("b2b_busy", 32'(busy), 32'd1);
      drain();
      held_sum  = 8'hFF;
      held_cout = 1'b0;

      // Reset and start on the same edge: reset wins.
      @(negedge clk);
      rst   = 1'b1;
      start = 1'b1;
      a_drv = 8'h01;
      b_drv = 8'h01;
      @(negedge clk);
      rst   = 1'b0;
      start = 1'b0;
      chk("rs_busy", 32'(busy), 32'd0);
      chk("rs_done", 32'(done), 32'd0);
      chk("rs_sum", 32'(sum), 32'd0);
      @(negedge clk);
      chk("rs_idle", 32'(busy), 32'd0);
      held_sum  = '0;
      held_cout = 1'b0;

      for (int i = 0; i < 40; i++) begin
         do_add(W'($urandom), W'($urandom));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      repeat (W + 2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
